// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit results,
// with flush masking and a one-cycle registered broadcast stage.
module cdb_arbiter #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4,
    parameter int BUF_SIZE  = 16,
    parameter int N_REQ     = 4,
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][XLEN-1:0]          req_data,
    input  logic [N_REQ-1:0][TAG_WIDTH:0]       req_rob_tag,
    input  logic [N_REQ-1:0]                    req_exception,
    input  logic [N_REQ-1:0]                    req_branch_mispredict,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic                                flush,
    input  logic [BUF_SIZE-1:0]                 rob_flush,
    output logic                                cdb_valid,
    output logic [XLEN-1:0]                     cdb_data,
    output logic [TAG_WIDTH:0]                  cdb_rob_tag,
    output logic                                cdb_exception,
    output logic                                cdb_branch_mispredict,
    output logic [IDX_W-1:0]                    cdb_grant_id
);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_cdb_valid;
    logic [XLEN-1:0]    r_cdb_data;
    logic [TAG_WIDTH:0] r_cdb_rob_tag;
    logic               r_cdb_exception;
    logic               r_cdb_branch_mispredict;
    logic [IDX_W-1:0]   r_cdb_grant_id;

    logic [N_REQ-1:0]   w_eligible;
    logic               w_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W:0]     w_scan;
    logic [N_REQ-1:0]   w_ready;
    logic [IDX_W-1:0]   w_rr_next;

    // Eligibility: valid, out of reset, and not targeting a ROB entry being flushed.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = reset && req_valid[i]
                            && !(flush && rob_flush[req_rob_tag[i][TAG_WIDTH-1:0]]);
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(N_REQ)) begin
                w_scan = w_scan - (IDX_W+1)'(N_REQ);
            end else begin
                w_scan = w_scan;
            end
            if (!w_found && w_eligible[w_scan[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[IDX_W-1:0];
            end else begin
                w_found   = w_found;
            end
        end
    end

    // One-hot grant vector and the pointer value following this grant.
    always_comb begin
        w_ready   = '0;
        w_rr_next = r_rr_ptr;
        if (w_found) begin
            w_ready[w_gnt_idx] = 1'b1;
            if (w_gnt_idx == IDX_W'(N_REQ - 1)) begin
                w_rr_next = '0;
            end else begin
                w_rr_next = w_gnt_idx + IDX_W'(1);
            end
        end else begin
            w_ready   = '0;
            w_rr_next = r_rr_ptr;
        end
    end

    // Broadcast register; without a new transfer valid drops, which also retires
    // any in-flight broadcast whose tag is being flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr                <= '0;
            r_cdb_valid             <= 1'b0;
            r_cdb_data              <= '0;
            r_cdb_rob_tag           <= '0;
            r_cdb_exception         <= 1'b0;
            r_cdb_branch_mispredict <= 1'b0;
            r_cdb_grant_id          <= '0;
        end else if (w_found) begin
            r_rr_ptr                <= w_rr_next;
            r_cdb_valid             <= 1'b1;
            r_cdb_data              <= req_data[w_gnt_idx];
            r_cdb_rob_tag           <= req_rob_tag[w_gnt_idx];
            r_cdb_exception         <= req_exception[w_gnt_idx];
            r_cdb_branch_mispredict <= req_branch_mispredict[w_gnt_idx];
            r_cdb_grant_id          <= w_gnt_idx;
        end else begin
            r_cdb_valid             <= 1'b0;
        end
    end

    assign req_ready             = w_ready;
    assign cdb_valid             = r_cdb_valid;
    assign cdb_data              = r_cdb_data;
    assign cdb_rob_tag           = r_cdb_rob_tag;
    assign cdb_exception         = r_cdb_exception;
    assign cdb_branch_mispredict = r_cdb_branch_mispredict;
    assign cdb_grant_id          = r_cdb_grant_id;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 32, data width.
- TAG_WIDTH, 4, ROB index width; tags are TAG_WIDTH+1 bits, and the MSB is the wrap bit.
- BUF_SIZE, 16, ROB entries.
- N_REQ, 4, number of functional-unit requesters.
- IDX_W, $clog2(N_REQ), requester index width.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- req_valid, in, N_REQ, per-requester result valid.
- req_data, in, N_REQ x XLEN, result value.
- req_rob_tag, in, N_REQ x (TAG_WIDTH+1), destination ROB tag.
- req_exception, in, N_REQ, exception flag.
- req_branch_mispredict, in, N_REQ, mispredict flag.
- req_ready, out, N_REQ, grant; a transfer occurs when valid and ready are both high.
- flush, in, 1, pipeline flush.
- rob_flush, in, BUF_SIZE, ROB entries being flushed.
- cdb_valid, out, 1, CDB broadcast valid.
- cdb_data, out, XLEN, broadcast value.
- cdb_rob_tag, out, TAG_WIDTH+1, broadcast tag.
- cdb_exception, out, 1, broadcast exception.
- cdb_branch_mispredict, out, 1, broadcast mispredict.
- cdb_grant_id, out, IDX_W, requester index of the current broadcast.

Function
REQ-003 The block SHALL grant at most one requester per cycle; req_ready SHALL be one-hot or zero.
REQ-004 A request is eligible when req_valid[i] is 1, except when flush=1 and rob_flush[req_rob_tag[i][TAG_WIDTH-1:0]]=1.
REQ-005 Arbitration SHALL be round-robin. The search starts at rr_ptr, ascends, and wraps from N_REQ-1 to 0. The first eligible requester wins.
REQ-006 req_ready SHALL be combinational from req_valid, the tags, flush, rob_flush and rr_ptr. Requesters SHALL NOT make req_valid depend on req_ready.
REQ-007 While valid=1 and ready=0, a requester SHALL hold its payload stable. The block SHALL tolerate a requester dropping valid when its tag is flushed.
REQ-008 On the clock edge ending a transfer cycle, the output registers SHALL capture the granted payload and index, and cdb_valid SHALL be 1. Latency is exactly 1 cycle from grant to broadcast.
REQ-009 In a cycle with no transfer, cdb_valid SHALL be 0 on the next edge. cdb_data, cdb_rob_tag, cdb_exception, cdb_branch_mispredict and cdb_grant_id SHALL hold their last values.
REQ-010 On a transfer from index g, rr_ptr SHALL become (g+1) mod N_REQ. Without a transfer, rr_ptr SHALL be unchanged.
REQ-011 A continuously valid requester SHALL be granted within N_REQ cycles (starvation bound).
REQ-012 If flush is high and the broadcast currently in the output register targets a flushed entry, cdb_valid SHALL be forced to 0 on the next edge. The block SHALL NOT rebroadcast it.
REQ-013 If every valid requester is masked by flush, there SHALL be no grant, rr_ptr SHALL hold, and cdb_valid SHALL be 0 next cycle.
REQ-014 The tag wrap bit SHALL be passed through unmodified. Only the low TAG_WIDTH bits SHALL index rob_flush.
REQ-015 Back-to-back grants SHALL sustain 1 broadcast per cycle with no bubble.

Reset
REQ-016 While reset=0, asynchronously: cdb_valid=0, cdb_data=0, cdb_rob_tag=0, cdb_exception=0, cdb_branch_mispredict=0, cdb_grant_id=0, rr_ptr=0.
REQ-017 While reset=0, req_ready SHALL be all zero.
REQ-018 Reset asserted mid-broadcast SHALL drop cdb_valid immediately. Arbitration SHALL resume from rr_ptr=0 on the first edge after reset deasserts.

Verification
REQ-019 Single request: after reset, req_valid=0001 with data 0x78675645, tag 0. Required: req_ready=0001 the same cycle; next cycle cdb_valid=1, cdb_data=0x78675645, cdb_rob_tag=0, cdb_grant_id=0; the cycle after, cdb_valid=0.
REQ-020 All four requesters valid continuously, with tags 1..4. Required: grants in order 0,1,2,3,0 on consecutive cycles; cdb_valid stays 1 throughout.
REQ-021 Pointer wrap: rr_ptr=3, with requesters 1 and 3 valid. Required: grant to 3, then to 1 next cycle, then rr_ptr=2.
REQ-022 Flush mask: requester 0 has tag 6 and requester 1 has tag 2; flush=1, rob_flush=0x03C0. Required: requester 0 is skipped, requester 1 is granted, and cdb_rob_tag=2 next cycle.
REQ-023 Flush of an in-flight broadcast: cdb_rob_tag=7 with cdb_valid=1, then flush=1 with rob_flush=0x0080 and no requests. Required: cdb_valid=0 on the next edge.
REQ-024 Asynchronous reset pulse while cdb_valid=1. Required: cdb_valid=0 before the next clk edge, and the first post-reset grant is the lowest-indexed valid requester.
